// File: rtl/avg_state_seq.sv
// Vector-generator state sequencer: a PROM-driven state machine that alternates
// address/latch phases. Build with AVG_SINGLE_STEP_EN to add the step input.
module avg_state_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       go,
    input  logic [2:0] op,
    input  logic       op_valid,
    input  logic       fetch_ack,
    input  logic       timer_done,
`ifdef AVG_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic [7:0] rom_addr,
    output logic       rom_cs,
    input  logic [3:0] rom_data,
    output logic [3:0] state,
    output logic       st_strobe,
    output logic       fetch_req,
    output logic       halted
);

    typedef enum logic {
        PH_ADDR  = 1'b0,
        PH_LATCH = 1'b1
    } phase_t;

    phase_t     phase_q, phase_d;
    logic [3:0] state_q, state_d;
    logic       halted_q, halted_d;
    logic       strobe_q, strobe_d;
    logic [2:0] op_q;
    logic       hold_c;
    logic       step_ok;
    logic       fetch_st;

`ifdef AVG_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    // States 1 and 2 are instruction fetches; state F waits on the draw timer.
    assign fetch_st = (state_q == 4'h1) || (state_q == 4'h2);
    assign hold_c   = ((state_q == 4'hF) && !timer_done) || (fetch_st && !fetch_ack);

    // op is captured on every valid cycle so the PROM sees the latest opcode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            op_q <= 3'b000;
        else if (op_valid)
            op_q <= op;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= PH_ADDR;
            state_q  <= 4'h0;
            halted_q <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            state_q  <= state_d;
            halted_q <= halted_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        state_d  = state_q;
        halted_d = halted_q;
        strobe_d = 1'b0;
        if (halted_q) begin
            // go restarts from state 0 even with the enable low.
            if (go) begin
                halted_d = 1'b0;
                phase_d  = PH_ADDR;
                state_d  = 4'h0;
            end
        end else if (clk_en) begin
            unique case (phase_q)
                PH_ADDR: begin
                    if (!hold_c)
                        phase_d = PH_LATCH;
                end
                PH_LATCH: begin
                    if (step_ok) begin
                        state_d  = rom_data;
                        phase_d  = PH_ADDR;
                        strobe_d = 1'b1;
                        halted_d = (rom_data == 4'h0);
                    end
                end
                default: phase_d = PH_ADDR;
            endcase
        end
    end

    assign rom_addr  = {halted_q, op_q, state_q};
    assign rom_cs    = !halted_q && (phase_q == PH_ADDR);
    assign fetch_req = !halted_q && (phase_q == PH_ADDR) && fetch_st;
    assign state     = state_q;
    assign st_strobe = strobe_q;
    assign halted    = halted_q;

endmodule

// File: doc/avg_state_seq.md
AVG_STATE_SEQ -- requirements
Module: avg_state_seq

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 clk_en  in  1  vector-generator clock enable; sequencer advances only on clk edges with clk_en=1.
REQ-004 go  in  1  one-cycle start pulse from CPU VG-go write.
REQ-005 op  in  3  opcode field of the current VG instruction word.
REQ-006 op_valid  in  1  op is valid this cycle.
REQ-007 fetch_ack  in  1  instruction memory has completed the requested fetch.
REQ-008 timer_done  in  1  vector draw timer has expired.
REQ-009 rom_addr  out  8  state-PROM address = {halted, op_q[2:0], state[3:0]}.
REQ-010 rom_cs  out  1  PROM chip select.
REQ-011 rom_data  in  4  PROM next-state output; registered, valid one clk after rom_addr.
REQ-012 state  out  4  current sequencer state.
REQ-013 st_strobe  out  1  one-clk pulse on every state update.
REQ-014 fetch_req  out  1  instruction-fetch request.
REQ-015 halted  out  1  sequencer idle, awaiting go.

Function
REQ-016 op_q SHALL load op on any clk edge with op_valid=1, independent of clk_en.
REQ-017 The sequencer SHALL alternate two phases: ADDR (phase=0) and LATCH (phase=1), each consuming one clk_en cycle.
REQ-018 rom_cs SHALL be 1 in ADDR whenever halted=0, and 0 otherwise.
REQ-019 In ADDR with clk_en=1 and no hold condition, phase SHALL become 1.
REQ-020 Hold condition: state=4'hF and timer_done=0, or state in {4'h1,4'h2} and fetch_ack=0; while held, phase, state and rom_addr SHALL remain unchanged.
REQ-021 fetch_req SHALL be 1 while halted=0, phase=0 and state is 4'h1 or 4'h2; it SHALL drop in the cycle after fetch_ack is sampled high.
REQ-022 In LATCH with clk_en=1, state SHALL load rom_data, phase SHALL return to 0, and st_strobe SHALL pulse for exactly one clk.
REQ-023 If rom_data=4'h0 is loaded in LATCH, halted SHALL become 1 in the same edge.
REQ-024 While halted=1, phase and state SHALL hold and no st_strobe SHALL occur.
REQ-025 go=1 while halted=1 SHALL clear halted and force phase=0, state=4'h0 on that edge, regardless of clk_en.
REQ-026 go while halted=0 SHALL be ignored.
REQ-027 State transition latency: one state update per two enabled cycles, plus any hold cycles.

Reset
REQ-028 reset SHALL asynchronously force state=4'h0, phase=0, halted=1, op_q=3'b000, st_strobe=0, fetch_req=0 and rom_cs=0, giving rom_addr=8'h80.
REQ-029 reset asserted mid-fetch or mid-wait SHALL abandon the operation; fetch_req SHALL drop immediately.

Configuration
REQ-030 With AVG_SINGLE_STEP_EN defined, an extra input step (1 bit) SHALL be present, and each LATCH SHALL additionally require step=1 on that cycle, giving one state transition per step pulse.
REQ-031 Without AVG_SINGLE_STEP_EN, the step port SHALL be absent and the sequencer SHALL free-run.

Verification
REQ-032 Reset released, no go -> halted=1, rom_addr=8'h80, rom_cs=0, no st_strobe for 100 clks.
REQ-033 go pulse, op=3'b010, clk_en=1, PROM returns 4'h3 -> rom_addr=8'h20, then state=4'h3 with one st_strobe two clks after go.
REQ-034 state=4'h1, fetch_ack held low 10 clks, then pulsed -> fetch_req high for exactly those 10 clks plus the ack cycle, and state advances 2 clks after ack.
REQ-035 state=4'hF, timer_done low 50 clks -> state frozen and no st_strobe; timer_done=1 -> one transition follows.
REQ-036 PROM returns 4'h0 -> halted=1 and rom_addr[7]=1; a second go while running is ignored; reset asserted during a fetch -> fetch_req=0 asynchronously.
REQ-037 AVG_SINGLE_STEP_EN build with step low -> no transitions; three step pulses -> exactly three st_strobe pulses.
